// File: rtl/neuron_mac.sv
// neuron_mac: streaming signed multiply-accumulate with per-vector bias,
// arithmetic right scaling and signed saturation. It feeds the sigmoid LUT.
//
// state | meaning
// ------+----------------------------------------------------------------
// ACCUM | accepting (x,w) beats; ready_o=1; acc holds the running sum
// OUT   | result held on z_o/sat_o with valid_o=1 until downstream takes it
module neuron_mac #(
   parameter int width_p     = 8,
   parameter int acc_width_p = 24,
   parameter int shift_p     = 4
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               valid_i,
   output logic               ready_o,
   input  logic [width_p-1:0] x_i,
   input  logic [width_p-1:0] w_i,
   input  logic [width_p-1:0] bias_i,
   input  logic               last_i,
   output logic               valid_o,
   input  logic               ready_i,
   output logic [width_p-1:0] z_o,
   output logic               sat_o
);

   typedef enum logic {ACCUM = 1'b0, OUT = 1'b1} state_t;

   localparam logic signed [acc_width_p-1:0] MAX_V = acc_width_p'((2 ** (width_p - 1)) - 1);
   localparam logic signed [acc_width_p-1:0] MIN_V = -acc_width_p'(2 ** (width_p - 1));

   state_t                          r_state;
   state_t                          w_state_nxt;
   logic signed [acc_width_p-1:0]   r_acc;
   logic                            r_first;
   logic                            r_valid;
   logic [width_p-1:0]              r_z;
   logic                            r_sat;

   logic                            w_accept;
   logic                            w_take;
   logic signed [2*width_p-1:0]     w_prod;
   logic signed [acc_width_p-1:0]   w_prod_ext;
   logic signed [acc_width_p-1:0]   w_bias_sh;
   logic signed [acc_width_p-1:0]   w_acc_nxt;
   logic signed [acc_width_p-1:0]   w_s;
   logic [width_p-1:0]              w_z_nxt;
   logic                            w_sat_nxt;

   // ready_o is a function of state only; reset forces it low so nothing is
   // accepted while the stage is held in reset.
   assign ready_o = reset_i & (r_state == ACCUM);
   assign valid_o = r_valid;
   assign z_o     = r_z;
   assign sat_o   = r_sat;

   // Product, bias alignment, next accumulator value and saturated result.
   always_comb begin
      w_prod     = $signed(x_i) * $signed(w_i);
      w_prod_ext = acc_width_p'(w_prod);
      w_bias_sh  = acc_width_p'($signed(bias_i)) <<< shift_p;
      w_acc_nxt  = (r_first ? w_bias_sh : r_acc) + w_prod_ext;
      w_s        = w_acc_nxt >>> shift_p;
      w_z_nxt    = w_s[width_p-1:0];
      w_sat_nxt  = 1'b0;
      if (w_s > MAX_V) begin
         w_z_nxt   = MAX_V[width_p-1:0];
         w_sat_nxt = 1'b1;
      end else if (w_s < MIN_V) begin
         w_z_nxt   = MIN_V[width_p-1:0];
         w_sat_nxt = 1'b1;
      end
   end

   // Next-state logic and handshake qualifiers.
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_take      = 1'b0;
      case (r_state)
         ACCUM: begin
            w_accept = valid_i & ready_o;
            if (w_accept && last_i) w_state_nxt = OUT;
         end
         OUT: begin
            w_take = r_valid & ready_i;
            if (w_take) w_state_nxt = ACCUM;
         end
         default: w_state_nxt = ACCUM;
      endcase
   end

   // State register.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) r_state <= ACCUM;
      else          r_state <= w_state_nxt;
   end

   // Accumulator, first-beat flag and registered result.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         r_acc   <= '0;
         r_first <= 1'b1;
         r_valid <= 1'b0;
         r_z     <= '0;
         r_sat   <= 1'b0;
      end else begin
         if (w_accept) begin
            if (last_i) begin
               r_acc   <= '0;
               r_first <= 1'b1;
               r_valid <= 1'b1;
               r_z     <= w_z_nxt;
               r_sat   <= w_sat_nxt;
            end else begin
               r_acc   <= w_acc_nxt;
               r_first <= 1'b0;
            end
         end
         if (w_take) r_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_neuron_mac.sv
// Bench for neuron_mac: directed cases plus randomized vectors checked
// against an integer-arithmetic model of the weighted sum.
module tb_neuron_mac;

   logic       clk_i = 1'b0;
   logic       reset_i = 1'b0;
   logic       valid_i = 1'b0;
   logic       ready_o;
   logic [7:0] x_i = '0;
   logic [7:0] w_i = '0;
   logic [7:0] bias_i = '0;
   logic       last_i = 1'b0;
   logic       valid_o;
   logic       ready_i = 1'b0;
   logic [7:0] z_o;
   logic       sat_o;

   int n_checks = 0;
   int n_err    = 0;

   // model state: running integer sum of bias*16 + sum(x*w)
   int m_sum   = 0;
   bit m_first = 1'b1;

   neuron_mac #(.width_p(8), .acc_width_p(24), .shift_p(4)) dut (
      .clk_i  (clk_i),
      .reset_i(reset_i),
      .valid_i(valid_i),
      .ready_o(ready_o),
      .x_i    (x_i),
      .w_i    (w_i),
      .bias_i (bias_i),
      .last_i (last_i),
      .valid_o(valid_o),
      .ready_i(ready_i),
      .z_o    (z_o),
      .sat_o  (sat_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // floor(sum/16) then clip to signed 8 bits
   function automatic void ref_out(input int sum, output logic [7:0] z, output logic s);
      int q;
      q = sum / 16;
      if (sum < 0 && (sum % 16) != 0) q = q - 1;
      s = 1'b0;
      if (q > 127) begin
         q = 127; s = 1'b1;
      end else if (q < -128) begin
         q = -128; s = 1'b1;
      end
      z = 8'(q);
   endfunction

   // Present one beat and wait (bounded) until it is accepted.
   task automatic beat(input int x, input int w, input int b, input bit last);
      int n = 0;
      x_i = 8'(x); w_i = 8'(w); bias_i = 8'(b); last_i = last; valid_i = 1'b1;
      while (ready_o !== 1'b1 && n < 20) begin
         @(posedge clk_i); #1; n++;
      end
      if (n >= 20) chk("beat_accept_timeout", 32'(ready_o), 32'd1);
      @(posedge clk_i); #1;
      valid_i = 1'b0; last_i = 1'b0;
      if (m_first) m_sum = b * 16 + x * w;
      else         m_sum = m_sum + x * w;
      m_first = last;
   endtask

   task automatic bubble(input int n);
      valid_i = 1'b0;
      repeat (n) begin @(posedge clk_i); #1; end
   endtask

   // Check the pending result, then hand it off and check the bubble.
   task automatic collect(input string tag, input logic [7:0] ez, input logic es);
      chk({tag, "_valid"}, 32'(valid_o), 32'd1);
      chk({tag, "_z"},     32'(z_o),     32'(ez));
      chk({tag, "_sat"},   32'(sat_o),   32'(es));
      chk({tag, "_rdy_out"}, 32'(ready_o), 32'd0);
      ready_i = 1'b1;
      @(posedge clk_i); #1;
      ready_i = 1'b0;
      chk({tag, "_valid_clr"}, 32'(valid_o), 32'd0);
      chk({tag, "_rdy_back"},  32'(ready_o), 32'd1);
   endtask

   logic [7:0] mz;
   logic       ms;

   initial begin
      // reset state
      #2;
      chk("rst_ready", 32'(ready_o), 32'd0);
      chk("rst_valid", 32'(valid_o), 32'd0);
      chk("rst_z",     32'(z_o),     32'd0);
      chk("rst_sat",   32'(sat_o),   32'd0);
      @(posedge clk_i); #1;
      reset_i = 1'b1;
      #1;
      chk("post_rst_ready", 32'(ready_o), 32'd1);

      // 1: single beat 16*16 -> 16
      beat(16, 16, 0, 1'b1);
      ref_out(m_sum, mz, ms);
      chk("t1_model_z", 32'(mz), 32'd16);
      collect("t1", 8'd16, 1'b0);

      // 2: bias 2, three beats with bubbles -> 180/16 = 11
      beat(10, 20, 2, 1'b0);
      bubble(2);
      beat(-5, 8, 99, 1'b0);
      chk("t2_no_early_valid", 32'(valid_o), 32'd0);
      bubble(1);
      beat(3, -4, -77, 1'b1);
      collect("t2", 8'd11, 1'b0);

      // 3: saturation both ways
      beat(127, 127, 0, 1'b1);
      collect("t3_pos", 8'd127, 1'b1);
      beat(-128, 127, 0, 1'b1);
      collect("t3_neg", 8'h80, 1'b1);

      // 4: floor toward -inf
      beat(-1, 1, 0, 1'b1);
      collect("t4_neg1", 8'hFF, 1'b0);
      beat(1, 1, 0, 1'b1);
      collect("t4_pos1", 8'h00, 1'b0);

      // 5: backpressure, stray valid_i pulses must not be consumed
      beat(40, 8, 1, 1'b1);
      for (int i = 0; i < 5; i++) begin
         x_i = 8'($urandom); w_i = 8'($urandom); last_i = $urandom_range(0, 1);
         valid_i = 1'b1;
         @(posedge clk_i); #1;
         chk("t5_hold_valid", 32'(valid_o), 32'd1);
         chk("t5_hold_z",     32'(z_o),     32'd21);
         chk("t5_hold_rdy",   32'(ready_o), 32'd0);
      end
      valid_i = 1'b0; last_i = 1'b0;
      collect("t5", 8'd21, 1'b0);
      beat(16, 16, 0, 1'b1);
      collect("t5_after", 8'd16, 1'b0);

      // 6: reset mid-vector discards the partial sum
      beat(50, 50, 7, 1'b0);
      beat(60, 60, 0, 1'b0);
      reset_i = 1'b0; #1;
      chk("t6_rst_valid", 32'(valid_o), 32'd0);
      chk("t6_rst_ready", 32'(ready_o), 32'd0);
      m_first = 1'b1;
      @(posedge clk_i); #1;
      reset_i = 1'b1; #1;
      beat(4, 4, 0, 1'b1);
      collect("t6", 8'd1, 1'b0);

      // reset while a result is pending drops it immediately
      beat(100, 100, 0, 1'b1);
      chk("t6b_pending", 32'(valid_o), 32'd1);
      reset_i = 1'b0; #1;
      chk("t6b_valid_drop", 32'(valid_o), 32'd0);
      chk("t6b_z_clr",      32'(z_o),     32'd0);
      @(posedge clk_i); #1;
      reset_i = 1'b1; #1;

      // randomized vectors against the integer model
      for (int v = 0; v < 30; v++) begin
         int len;
         len = $urandom_range(1, 8);
         for (int k = 0; k < len; k++) begin
            int x, w, b;
            x = $urandom_range(0, 255) - 128;
            w = $urandom_range(0, 255) - 128;
            b = $urandom_range(0, 255) - 128;
            bubble($urandom_range(0, 2));
            beat(x, w, b, k == len - 1);
         end
         ref_out(m_sum, mz, ms);
         chk("rnd_latency", 32'(valid_o), 32'd1);
         repeat ($urandom_range(0, 3)) begin
            @(posedge clk_i); #1;
         end
         collect("rnd", mz, ms);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   // global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
